// File: rtl/led3_seq_driver.sv
// led3_seq_driver: drives a fixed 12-step switch sequence into the LED FSM and counts LED mismatches
module led3_seq_driver #(
  parameter int STEP_CYCLES = 100_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [2:0] led_in,
  output logic [2:0] sw_out,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_cnt,
  output logic [3:0] step_idx
);
  localparam int CW = $clog2(STEP_CYCLES);
  localparam logic [35:0] SW_TAB  = {3'b000, 3'b111, 3'b100, 3'b010, 3'b000, 3'b100,
                                     3'b010, 3'b011, 3'b100, 3'b010, 3'b001, 3'b000};
  localparam logic [35:0] EXP_TAB = {3'b000, 3'b111, 3'b100, 3'b010, 3'b000, 3'b100,
                                     3'b010, 3'b001, 3'b100, 3'b010, 3'b001, 3'b000};
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t         state, state_n;
  logic [CW-1:0]  cnt, cnt_n;
  logic [3:0]     idx_n, err_n;
  logic [2:0]     sw_n;
  logic           go, last, fin;
  always_comb begin
    go      = state != RUN && start;
    last    = state == RUN && cnt == CW'(STEP_CYCLES - 1);
    fin     = last && step_idx == 4'd11;
    state_n = go ? RUN : fin ? DONE : state;
    cnt_n   = (go || last) ? '0 : (state == RUN) ? cnt + 1'b1 : cnt;
    idx_n   = (go || fin) ? 4'd0 : last ? step_idx + 4'd1 : step_idx;
    err_n   = go ? 4'd0 : last ? err_cnt + {3'd0, led_in != EXP_TAB[6'(step_idx) * 6'd3 +: 3]} : err_cnt;
    sw_n    = (state_n == RUN) ? SW_TAB[6'(idx_n) * 6'd3 +: 3] : 3'd0;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      step_idx <= 4'd0;
      err_cnt  <= 4'd0;
      sw_out   <= 3'd0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      step_idx <= idx_n;
      err_cnt  <= err_n;
      sw_out   <= sw_n;
    end
  end
  assign busy = state == RUN;
  assign done = state == DONE;
  assign pass = done && err_cnt == 4'd0;
endmodule

// File: doc/led3_seq_driver.md
# led3_seq_driver

- Autonomous stimulus and checking engine for the 3-switch/3-LED Moore FSM (`fsm_moore_led3`).
- It sits on the switch side of that interface: it drives `sw_out` through a fixed 12-step switch sequence and holds each step for a programmable number of cycles.
- It samples the FSM's `led` output at the end of every step against a built-in expected table and reports a mismatch count and a pass flag.
- It allows on-board self-test of the LED FSM without manual switch toggling.

## Interface
- `STEP_CYCLES`, default 100_000_000: cycles each step is held (1 s at 100 MHz). Legal range is ≥ 2.
- `clk`  input  1  system clock; all logic is rising-edge.
- `reset`  input  1  synchronous, active-low reset.
- `start`  input  1  one-cycle (or level) request to run the sequence.
- `led_in`  input  3  LED output of the FSM under test.
- `sw_out`  output  3  switch pattern driven to the FSM's `sw` input; registered.
- `busy`  output  1  high while a sequence is running.
- `done`  output  1  high from sequence completion until the next accepted `start` or reset.
- `pass`  output  1  equals `done` AND (`err_cnt` == 0).
- `err_cnt`  output  4  number of mismatched steps in the current/last run (0–12).
- `step_idx`  output  4  current step index, 0–11; holds 0 when idle.

## Operation
- Reset (`reset` == 0 at a rising edge) forces the following, regardless of state, including mid-sequence:
  - state IDLE;
  - `sw_out`=000, `busy`=0, `done`=0, `pass`=0;
  - `err_cnt`=0, `step_idx`=0;
  - step counter = 0.
- Step table, given as step: `sw_out` / expected `led_in`:
  - 0: 000/000; 1: 001/001; 2: 010/010; 3: 100/100;
  - 4: 011/001; 5: 010/010; 6: 100/100; 7: 000/000;
  - 8: 010/010; 9: 100/100; 10: 111/111; 11: 000/000.
- The expected values encode the target FSM's LED code per state: S0=000, S1=001, S2=010, S3=100, S4=111.
- States: IDLE, RUN, DONE.
  - IDLE: `sw_out`=000. `start`=1 → RUN, step 0, step counter 0, `err_cnt` cleared.
  - RUN: `sw_out` = table[`step_idx`]. The step counter increments every cycle.
    - On the cycle the counter equals `STEP_CYCLES`−1, `led_in` is compared with expected[`step_idx`]; a mismatch increments `err_cnt` by 1.
    - In that same cycle the counter resets to 0 and `step_idx` increments. If `step_idx` was 11, go to DONE instead.
  - DONE: `sw_out`=000, `done`=1, `busy`=0, `step_idx`=0.
    - `start`=1 → RUN, exactly as from IDLE (`err_cnt` cleared, `done` dropped).
- `start` is ignored while in RUN.
- `err_cnt` never exceeds 12, so no saturation logic is needed. It is 4-bit unsigned.
- Step counter width is `$clog2(STEP_CYCLES)`; it must not wrap before `STEP_CYCLES`−1.

## Timing
- `start` high at edge t (in IDLE or DONE) → from edge t+1:
  - `busy`=1, `sw_out`=table[0], `step_idx`=0;
  - `done`=0, `pass`=0, `err_cnt`=0.
- Step k occupies exactly `STEP_CYCLES` cycles. `sw_out` changes only at step boundaries.
- `led_in` is sampled on the last cycle of each step. With the FSM's one-cycle register latency, this gives `STEP_CYCLES`−1 settle cycles, hence the minimum of 2.
- Total run length is 12 × `STEP_CYCLES` cycles.
- The edge after step 11's sample sets: `busy`=0, `done`=1, `sw_out`=000. `pass` is valid in that same cycle.
- The final mismatch (step 11) is already included in `err_cnt` when `done` rises.
- `reset` low mid-RUN: outputs take their reset values at that edge. No partial result is retained.
- `start` and `reset` asserted in the same cycle: reset wins.

## Test plan
- **Nominal run:** `STEP_CYCLES`=4, with `led_in` driven by a behavioural LED FSM (S0–S4 transitions per table), `start` pulsed.
  - `sw_out` walks 000, 001, 010, 100, 011, 010, 100, 000, 010, 100, 111, 000, 4 cycles each.
  - `done`=1 and `pass`=1 exactly 48 cycles after start, with `err_cnt`=0.
- **Stuck LEDs:** `led_in` tied to 000 → `done`=1, `err_cnt`=9 (steps 1–6, 8–10), `pass`=0.
- **Single fault:** model forced to output 100 instead of 001 at step 4 only → `err_cnt`=1, `pass`=0.
- **Start while busy:** pulse `start` again at step 5 → the sequence continues uninterrupted and completes at cycle 48.
- **Reset mid-run:** `reset`=0 for one cycle at step 6 → next cycle `busy`=0, `sw_out`=000, `err_cnt`=0, `step_idx`=0.
  - A subsequent `start` runs the full sequence from step 0.
- **Restart from DONE:** after the stuck-LED run (`err_cnt`=9), connect the good model and pulse `start`.
  - `err_cnt` clears to 0 on the next cycle.
  - The run ends with `pass`=1.
